// File: rtl/wfg_stim_sweep_pkg.sv
// ----------------------------------------------------------------------------
// wfg_stim_sweep_pkg
// Shared types and widths for the sine-stimulus frequency-sweep scheduler.
//   state_t : sweep controller states (IDLE / SWEEP / DONE)
//   mode_t  : sweep shapes, encoded as they appear on cfg_mode_i
//   INC_W   : angular-increment width
//   CNT_W   : dwell / sweep counter width
// ----------------------------------------------------------------------------
package wfg_stim_sweep_pkg;

    localparam int INC_W = 16;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // MODE_RSVD behaves exactly like MODE_SINGLE.
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

endpackage

// File: rtl/wfg_stim_sweep_step.sv
// ----------------------------------------------------------------------------
// wfg_stim_sweep_step
// Combinational single-step calculator: moves an increment one step toward a
// target, clamping at the target, with step 0 meaning "jump to target".
//   i_cur       : current increment
//   i_target    : increment being approached
//   i_step      : unsigned step magnitude
//   o_next_inc  : increment after one step
//   o_at_target : i_cur already equals i_target
// ----------------------------------------------------------------------------
module wfg_stim_sweep_step
    import wfg_stim_sweep_pkg::*;
(
    input  logic [INC_W-1:0] i_cur,
    input  logic [INC_W-1:0] i_target,
    input  logic [INC_W-1:0] i_step,
    output logic [INC_W-1:0] o_next_inc,
    output logic             o_at_target
);

    // One extra bit so neither direction can wrap past 0 or 0xFFFF.
    logic [INC_W:0] w_up;
    logic [INC_W:0] w_dn;

    assign w_up = {1'b0, i_cur} + {1'b0, i_step};
    assign w_dn = {1'b0, i_cur} - {1'b0, i_step};

    always_comb begin
        o_next_inc = i_target;
        if (i_step != '0) begin
            if (i_cur < i_target) begin
                if (w_up < {1'b0, i_target}) begin
                    o_next_inc = w_up[INC_W-1:0];
                end
            end else if (i_cur > i_target) begin
                // w_dn[INC_W] set means the step went below zero: clamp.
                if (!w_dn[INC_W] && (w_dn[INC_W-1:0] > i_target)) begin
                    o_next_inc = w_dn[INC_W-1:0];
                end
            end
        end
    end

    assign o_at_target = (i_cur == i_target);

endmodule

// File: rtl/wfg_stim_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// wfg_stim_sweep_ctrl
// Frequency-sweep scheduler for the sine stimulus generator. Steps the
// generator increment from a start value toward a stop value, advancing once
// every "dwell" accepted output samples (observed AXI-stream handshakes).
// Supports single-shot, sawtooth-repeat and triangle sweeps.
//   clk, rst_n        : clock, asynchronous active-low reset
//   cfg_en_i          : sweep enable (level); low aborts a running sweep
//   cfg_mode_i        : 00 single, 01 sawtooth, 10 triangle, 11 single
//   cfg_start_inc_i   : first increment
//   cfg_stop_inc_i    : end increment
//   cfg_step_inc_i    : step magnitude (0 = jump to target)
//   cfg_dwell_i       : accepted samples per step (0 = 1)
//   stim_tvalid_i/..  : generator output handshake, observed only
//   sine_en_o         : generator enable, high exactly while sweeping
//   sine_inc_o        : generator increment
//   busy_o            : high while sweeping
//   done_o            : one-cycle pulse when a single sweep completes
//   sweep_cnt_o       : endpoint events since sweep start (wrapping)
// Valid/ready: a sample counts only in a cycle where stim_tvalid_i and
// stim_tready_i are both high; tvalid with tready low is a stall and leaves
// every counter untouched.
// ----------------------------------------------------------------------------
module wfg_stim_sweep_ctrl
    import wfg_stim_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en_i,
    input  logic [1:0]       cfg_mode_i,
    input  logic [INC_W-1:0] cfg_start_inc_i,
    input  logic [INC_W-1:0] cfg_stop_inc_i,
    input  logic [INC_W-1:0] cfg_step_inc_i,
    input  logic [CNT_W-1:0] cfg_dwell_i,
    input  logic             stim_tvalid_i,
    input  logic             stim_tready_i,
    output logic             sine_en_o,
    output logic [INC_W-1:0] sine_inc_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sweep_cnt_o
);

    state_t           r_state;
    mode_t            r_mode;
    logic [INC_W-1:0] r_start;
    logic [INC_W-1:0] r_stop;
    logic [INC_W-1:0] r_step;
    logic [CNT_W-1:0] r_dwell;
    logic [INC_W-1:0] r_target;
    logic [CNT_W-1:0] r_dwell_cnt;
    logic [INC_W-1:0] r_inc;
    logic [CNT_W-1:0] r_sweep_cnt;
    logic             r_sine_en;
    logic             r_busy;
    logic             r_done;

    logic             w_hs;
    logic             w_dwell_last;
    logic [INC_W-1:0] w_swap_target;
    logic [INC_W-1:0] w_next_inc;
    logic             w_at_target;
    logic [INC_W-1:0] w_tri_inc;
    logic             w_tri_at_target_unused;

    assign w_hs         = stim_tvalid_i & stim_tready_i;
    // r_dwell is never 0 (0 is loaded as 1), so the subtraction cannot wrap.
    assign w_dwell_last = (r_dwell_cnt == (r_dwell - 16'd1));

    // Triangle turnaround: the target flips to the opposite endpoint.
    assign w_swap_target = (r_target == r_stop) ? r_start : r_stop;

    // Normal advance toward the current target.
    wfg_stim_sweep_step u_step_fwd (
        .i_cur       (r_inc),
        .i_target    (r_target),
        .i_step      (r_step),
        .o_next_inc  (w_next_inc),
        .o_at_target (w_at_target)
    );

    // Triangle endpoint: step away toward the new target in the same cycle
    // so the endpoint value is not dwelt on twice.
    wfg_stim_sweep_step u_step_tri (
        .i_cur       (r_inc),
        .i_target    (w_swap_target),
        .i_step      (r_step),
        .o_next_inc  (w_tri_inc),
        .o_at_target (w_tri_at_target_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_SINGLE;
            r_start     <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_dwell     <= 16'd1;
            r_target    <= '0;
            r_dwell_cnt <= '0;
            r_inc       <= '0;
            r_sweep_cnt <= '0;
            r_sine_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_en_i) begin
                        r_mode      <= mode_t'(cfg_mode_i);
                        r_start     <= cfg_start_inc_i;
                        r_stop      <= cfg_stop_inc_i;
                        r_step      <= cfg_step_inc_i;
                        r_dwell     <= (cfg_dwell_i == '0) ? 16'd1 : cfg_dwell_i;
                        r_target    <= cfg_stop_inc_i;
                        r_inc       <= cfg_start_inc_i;
                        r_dwell_cnt <= '0;
                        r_sweep_cnt <= '0;
                        r_sine_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SWEEP;
                    end
                end

                ST_SWEEP: begin
                    if (!cfg_en_i) begin
                        // Abort wins over any advance in the same cycle.
                        r_sine_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_hs) begin
                        if (w_dwell_last) begin
                            r_dwell_cnt <= '0;
                            if (!w_at_target) begin
                                r_inc <= w_next_inc;
                            end else begin
                                r_sweep_cnt <= r_sweep_cnt + 16'd1;
                                case (r_mode)
                                    MODE_SAW: begin
                                        r_inc <= r_start;
                                    end
                                    MODE_TRI: begin
                                        r_target <= w_swap_target;
                                        r_inc    <= w_tri_inc;
                                    end
                                    default: begin
                                        r_sine_en <= 1'b0;
                                        r_busy    <= 1'b0;
                                        r_done    <= 1'b1;
                                        r_state   <= ST_DONE;
                                    end
                                endcase
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + 16'd1;
                        end
                    end
                end

                ST_DONE: begin
                    if (!cfg_en_i) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_sine_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign sine_en_o   = r_sine_en;
    assign sine_inc_o  = r_inc;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign sweep_cnt_o = r_sweep_cnt;

endmodule

// File: tb/tb_wfg_stim_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_wfg_stim_sweep_ctrl
// Self-checking bench: directed vector table, hand-written corner sequences
// (backpressure, abort, asynchronous reset) and a randomized run checked
// against a sequence-list reference model.
// ----------------------------------------------------------------------------
module tb_wfg_stim_sweep_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_start;
    logic [15:0] cfg_stop;
    logic [15:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic        tvalid;
    logic        tready;
    logic        sine_en;
    logic [15:0] sine_inc;
    logic        busy;
    logic        done;
    logic [15:0] sweep_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wfg_stim_sweep_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_en_i        (cfg_en),
        .cfg_mode_i      (cfg_mode),
        .cfg_start_inc_i (cfg_start),
        .cfg_stop_inc_i  (cfg_stop),
        .cfg_step_inc_i  (cfg_step),
        .cfg_dwell_i     (cfg_dwell),
        .stim_tvalid_i   (tvalid),
        .stim_tready_i   (tready),
        .sine_en_o       (sine_en),
        .sine_inc_o      (sine_inc),
        .busy_o          (busy),
        .done_o          (done),
        .sweep_cnt_o     (sweep_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [1:0]        mode;
        logic [15:0]       start;
        logic [15:0]       stop;
        logic [15:0]       step;
        logic [15:0]       dwell;
        logic [3:0]        n;
        logic [0:7][15:0]  seq;
        logic [0:7][15:0]  cnt;
        logic              single;
    } vec_t;

    vec_t vecs[8];

    task automatic set_vec(input int i, input logic [1:0] m, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] s, input logic [15:0] d,
                           input logic [3:0] n, input logic sgl);
        vecs[i].mode   = m;
        vecs[i].start  = a;
        vecs[i].stop   = b;
        vecs[i].step   = s;
        vecs[i].dwell  = d;
        vecs[i].n      = n;
        vecs[i].single = sgl;
        vecs[i].cnt    = '0;
    endtask

    task automatic fill_table();
        set_vec(0, 2'b00, 16'h0100, 16'h0400, 16'h0100, 16'd2, 4'd4, 1'b1);
        vecs[0].seq = {16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0};
        set_vec(1, 2'b00, 16'h0100, 16'h0350, 16'h0100, 16'd1, 4'd4, 1'b1);
        vecs[1].seq = {16'h0100, 16'h0200, 16'h0300, 16'h0350, 16'h0, 16'h0, 16'h0, 16'h0};
        set_vec(2, 2'b00, 16'h0400, 16'h0100, 16'h0180, 16'd1, 4'd3, 1'b1);
        vecs[2].seq = {16'h0400, 16'h0280, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        set_vec(3, 2'b10, 16'h0010, 16'h0030, 16'h0010, 16'd1, 4'd7, 1'b0);
        vecs[3].seq = {16'h0010, 16'h0020, 16'h0030, 16'h0020, 16'h0010, 16'h0020, 16'h0030, 16'h0};
        vecs[3].cnt = {16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd0};
        set_vec(4, 2'b01, 16'h0010, 16'h0030, 16'h0010, 16'd1, 4'd5, 1'b0);
        vecs[4].seq = {16'h0010, 16'h0020, 16'h0030, 16'h0010, 16'h0020, 16'h0, 16'h0, 16'h0};
        vecs[4].cnt = {16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0};
        set_vec(5, 2'b00, 16'h0100, 16'h0800, 16'h0000, 16'd1, 4'd2, 1'b1);
        vecs[5].seq = {16'h0100, 16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        set_vec(6, 2'b00, 16'h0100, 16'h0300, 16'h0100, 16'd0, 4'd3, 1'b1);
        vecs[6].seq = {16'h0100, 16'h0200, 16'h0300, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        set_vec(7, 2'b11, 16'h0010, 16'h0030, 16'h0010, 16'd1, 4'd3, 1'b1);
        vecs[7].seq = {16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    endtask

    task automatic go_idle();
        cfg_en = 1'b0;
        tvalid = 1'b0;
        tready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_sweep(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] s, input logic [15:0] d);
        cfg_mode  = m;
        cfg_start = a;
        cfg_stop  = b;
        cfg_step  = s;
        cfg_dwell = d;
        cfg_en    = 1'b1;
        tvalid    = 1'b1;
        tready    = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        int   d;
        v = vecs[vi];
        d = (v.dwell == 16'd0) ? 1 : int'(v.dwell);
        go_idle();
        start_sweep(v.mode, v.start, v.stop, v.step, v.dwell);
        chk($sformatf("v%0d sine_en", vi), {15'b0, sine_en}, 16'd1);
        chk($sformatf("v%0d busy", vi), {15'b0, busy}, 16'd1);
        for (int p = 0; p < int'(v.n); p++) begin
            for (int h = 0; h < d; h++) begin
                chk($sformatf("v%0d inc p%0d", vi, p), sine_inc, v.seq[p]);
                chk($sformatf("v%0d cnt p%0d", vi, p), sweep_cnt, v.cnt[p]);
                // Scramble cfg to confirm shadows hold.
                cfg_start = 16'hDEAD;
                cfg_step  = 16'h0001;
                @(negedge clk);
            end
        end
        if (v.single) begin
            chk($sformatf("v%0d done", vi), {15'b0, done}, 16'd1);
            chk($sformatf("v%0d en_off", vi), {15'b0, sine_en}, 16'd0);
            chk($sformatf("v%0d busy_off", vi), {15'b0, busy}, 16'd0);
            chk($sformatf("v%0d cnt_end", vi), sweep_cnt, 16'd1);
            chk($sformatf("v%0d inc_hold", vi), sine_inc, v.seq[v.n - 1]);
            @(negedge clk);
            chk($sformatf("v%0d done_pulse", vi), {15'b0, done}, 16'd0);
            chk($sformatf("v%0d stay_done", vi), {15'b0, sine_en}, 16'd0);
        end
        cfg_en = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d off", vi), {15'b0, sine_en}, 16'd0);
        chk($sformatf("v%0d no_done", vi), {15'b0, done}, 16'd0);
    endtask

    // ---------------- reference model ----------------
    // The sweep is a list of positions (value, ends-a-ramp); each position
    // lasts dwell handshakes.
    int pos_val[300];
    bit pos_end[300];
    int n_pos;
    bit m_single;
    int m_dwell;
    int ramp_q[$];

    int          m_state;  // 0 idle, 1 sweeping, 2 finished
    int          m_hs;
    logic [15:0] m_inc;
    logic [15:0] m_cnt;
    bit          m_done;

    function automatic void make_ramp(input int a, input int b, input int s);
        int v;
        v = a;
        ramp_q = {};
        ramp_q.push_back(v);
        while (v != b) begin
            if (s == 0)      v = b;
            else if (v < b)  v = (v + s >= b) ? b : v + s;
            else             v = (v - s <= b) ? b : v - s;
            ramp_q.push_back(v);
        end
    endfunction

    function automatic void add_pos(input int v, input bit e);
        if (n_pos < 300) begin
            pos_val[n_pos] = v;
            pos_end[n_pos] = e;
            n_pos++;
        end
    endfunction

    function automatic void build(input int md, input int a, input int b, input int s);
        int from;
        int to;
        int t;
        n_pos    = 0;
        m_single = (md == 0) || (md == 3);
        if (m_single) begin
            make_ramp(a, b, s);
            foreach (ramp_q[i]) add_pos(ramp_q[i], i == ramp_q.size() - 1);
        end else if (a == b) begin
            while (n_pos < 256) add_pos(a, 1'b1);
        end else if (md == 1) begin
            while (n_pos < 256) begin
                make_ramp(a, b, s);
                foreach (ramp_q[i]) add_pos(ramp_q[i], i == ramp_q.size() - 1);
            end
        end else begin
            make_ramp(a, b, s);
            foreach (ramp_q[i]) add_pos(ramp_q[i], i == ramp_q.size() - 1);
            from = b;
            to   = a;
            while (n_pos < 256) begin
                make_ramp(from, to, s);
                for (int i = 1; i < ramp_q.size(); i++) add_pos(ramp_q[i], i == ramp_q.size() - 1);
                t    = from;
                from = to;
                to   = t;
            end
        end
    endfunction

    task automatic model_edge(input bit en, input bit hs);
        int idx;
        m_done = 1'b0;
        case (m_state)
            0: if (en) begin
                build(int'(cfg_mode), int'(cfg_start), int'(cfg_stop), int'(cfg_step));
                m_dwell = (cfg_dwell == 16'd0) ? 1 : int'(cfg_dwell);
                m_hs    = 0;
                m_inc   = pos_val[0][15:0];
                m_cnt   = 16'd0;
                m_state = 1;
            end
            1: if (!en) m_state = 0;
               else if (hs) begin
                   m_hs++;
                   if (m_hs % m_dwell == 0) begin
                       idx = m_hs / m_dwell;
                       if (pos_end[idx-1]) m_cnt = m_cnt + 16'd1;
                       if (m_single && idx == n_pos) begin
                           m_state = 2;
                           m_done  = 1'b1;
                       end else begin
                           m_inc = pos_val[idx][15:0];
                       end
                   end
               end
            default: if (!en) m_state = 0;
        endcase
    endtask

    task automatic rand_cfg();
        int diff;
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_start = 16'($urandom_range(0, 65535));
        cfg_stop  = ($urandom_range(0, 7) == 0) ? cfg_start : 16'($urandom_range(0, 65535));
        diff      = (cfg_stop > cfg_start) ? int'(cfg_stop - cfg_start) : int'(cfg_start - cfg_stop);
        cfg_step  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'(diff / int'($urandom_range(1, 12)) + 1);
        cfg_dwell = 16'($urandom_range(0, 3));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        cfg_en    = 1'b0;
        cfg_mode  = 2'b00;
        cfg_start = 16'h0;
        cfg_stop  = 16'h0;
        cfg_step  = 16'h0;
        cfg_dwell = 16'h0;
        tvalid    = 1'b0;
        tready    = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst sine_en", {15'b0, sine_en}, 16'd0);
        chk("rst sine_inc", sine_inc, 16'd0);
        chk("rst busy", {15'b0, busy}, 16'd0);
        chk("rst done", {15'b0, done}, 16'd0);
        chk("rst sweep_cnt", sweep_cnt, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven directed vectors
        fill_table();
        for (int i = 0; i < 8; i++) run_vec(i);

        // Backpressure mid-dwell
        go_idle();
        start_sweep(2'b00, 16'h0100, 16'h0400, 16'h0100, 16'd3);
        @(negedge clk);
        tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp hold inc", sine_inc, 16'h0100);
        end
        chk("bp hold en", {15'b0, sine_en}, 16'd1);
        tready = 1'b1;
        @(negedge clk);
        chk("bp resume 2nd", sine_inc, 16'h0100);
        @(negedge clk);
        chk("bp resume 3rd", sine_inc, 16'h0200);
        repeat (3) @(negedge clk);
        chk("bp next step", sine_inc, 16'h0300);

        // Abort at step 2 and restart
        go_idle();
        start_sweep(2'b00, 16'h0100, 16'h0400, 16'h0100, 16'd1);
        @(negedge clk);
        chk("abort step2", sine_inc, 16'h0200);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("abort en", {15'b0, sine_en}, 16'd0);
        chk("abort busy", {15'b0, busy}, 16'd0);
        chk("abort no done", {15'b0, done}, 16'd0);
        chk("abort inc hold", sine_inc, 16'h0200);
        @(negedge clk);
        chk("abort no done 2", {15'b0, done}, 16'd0);
        cfg_en = 1'b1;
        @(negedge clk);
        chk("restart inc", sine_inc, 16'h0100);
        chk("restart en", {15'b0, sine_en}, 16'd1);
        chk("restart cnt", sweep_cnt, 16'd0);

        // Asynchronous reset mid-sweep
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst sine_en", {15'b0, sine_en}, 16'd0);
        chk("arst sine_inc", sine_inc, 16'd0);
        chk("arst busy", {15'b0, busy}, 16'd0);
        chk("arst cnt", sweep_cnt, 16'd0);
        cfg_en = 1'b0;
        tvalid = 1'b0;
        tready = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        m_state = 0;
        m_inc   = 16'd0;
        m_cnt   = 16'd0;
        m_done  = 1'b0;

        // Randomized run against the reference model
        for (int s = 0; s < 20; s++) begin
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                chk("rnd sine_en", {15'b0, sine_en}, {15'b0, m_state == 1});
                chk("rnd busy", {15'b0, busy}, {15'b0, m_state == 1});
                chk("rnd done", {15'b0, done}, {15'b0, m_done});
                chk("rnd sine_inc", sine_inc, m_inc);
                chk("rnd sweep_cnt", sweep_cnt, m_cnt);
                cfg_en = (c < 2) ? 1'b0 : ($urandom_range(0, 59) != 0);
                rand_cfg();
                tvalid = ($urandom_range(0, 3) != 0);
                tready = ($urandom_range(0, 2) != 0);
                model_edge(cfg_en, tvalid & tready);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wfg_stim_sweep_ctrl.md
# wfg_stim_sweep_ctrl

Frequency-sweep scheduler for the sine stimulus generator. It drives the generator's enable and angular-increment inputs and steps the increment from a start value toward a stop value. It advances one step after a programmed number of accepted output samples, counted by watching the generator's AXI-stream handshake. It sits between the register file and the sine generator and supports single-shot, sawtooth-repeat and triangle sweeps.

## Interface
Parameters:
- none; all widths fixed (increment 16 bit, dwell/sweep counters 16 bit)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  sweep enable (level)
- cfg_mode_i  in  2  00 single, 01 sawtooth repeat, 10 triangle, 11 treated as single
- cfg_start_inc_i  in  16  first increment
- cfg_stop_inc_i  in  16  end increment
- cfg_step_inc_i  in  16  step magnitude, unsigned; 0 = jump straight to target
- cfg_dwell_i  in  16  accepted samples per step; 0 treated as 1
- stim_tvalid_i  in  1  generator output valid (observed)
- stim_tready_i  in  1  downstream ready (observed)
- sine_en_o  out  1  to generator ctrl enable
- sine_inc_o  out  16  to generator increment
- busy_o  out  1  high in SWEEP
- done_o  out  1  one-cycle pulse on single-sweep completion
- sweep_cnt_o  out  16  endpoint events since start, wraps at 0xFFFF->0

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE: cfg_en_i=1 -> SWEEP.
  - On that transition: latch all cfg_* into shadow registers; sine_inc_o<=start; target<=stop; dwell_cnt<=0; sweep_cnt_o<=0.
- SWEEP:
  - Handshake = stim_tvalid_i & stim_tready_i. Each handshake increments dwell_cnt.
  - On the handshake where dwell_cnt==dwell-1: dwell_cnt<=0 and the increment advances.
  - Advance with inc!=target: move toward target by step. Clamp at target if step reaches or passes it. Step 0 jumps to target. Use 17-bit arithmetic, so no wrap-around.
  - Advance with inc==target is an endpoint event; sweep_cnt_o increments. Then by mode:
    - single: -> DONE.
    - sawtooth: inc<=start.
    - triangle: swap target between start and stop, and step inc toward the new target in the same cycle, so endpoints are not dwelt twice.
  - start==stop: every advance is an endpoint event.
  - cfg_en_i=0 -> IDLE next cycle, no done_o. Takes priority over a simultaneous advance.
- DONE: done_o pulses on the entry cycle only; -> IDLE when cfg_en_i=0.
- cfg_* changes during SWEEP/DONE are ignored; shadows are reloaded only at IDLE->SWEEP.
- sine_inc_o holds its last value in IDLE and DONE.

## Timing
- Reset values: sine_en_o 0, sine_inc_o 0, busy_o 0, done_o 0, sweep_cnt_o 0, state IDLE.
- All outputs are registered.
- sine_en_o = 1 exactly while in SWEEP. Asserts the cycle after cfg_en_i is seen high in IDLE; deasserts the cycle after abort or endpoint.
- sine_inc_o updates the cycle after the qualifying handshake. The sample in flight uses the old value; no handshake is dropped or double-counted.
- With tvalid high and tready low, all counters hold.
- Handshakes outside SWEEP are ignored.
- Reset mid-sweep returns immediately to reset values.

## Structure
- Package wfg_stim_sweep_pkg holds:
  - state enum (IDLE/SWEEP/DONE);
  - mode enum with the encodings above;
  - localparam widths.
- Sub-module wfg_stim_sweep_step, purely combinational:
  - inputs cur, target, step;
  - outputs next increment (clamped, step-0 jump) and at_target flag.
- Top level: FSM, shadow registers, dwell counter, sweep counter.

## Test plan
- Single, start 0x0100, stop 0x0400, step 0x0100, dwell 2, tready=1 -> sine_inc_o 0100,0200,0300,0400, each held for 2 handshakes. done_o pulses the cycle after the 8th handshake; sine_en_o 0; sweep_cnt_o 1.
- Clamp and descend:
  - start 0x0100, stop 0x0350, step 0x0100 -> 0100,0200,0300,0350.
  - start 0x0400, stop 0x0100, step 0x0180 -> 0400,0280,0100.
- Triangle, start 0x0010, stop 0x0030, step 0x0010, dwell 1 -> 10,20,30,20,10,20,30. sweep_cnt_o increments as each endpoint completes. Sawtooth with the same values -> 10,20,30,10,20.
- Backpressure: tready low for 10 cycles mid-dwell -> dwell_cnt and sine_inc_o frozen; sequence resumes unchanged.
- Edge configs:
  - step 0, start 0x0100, stop 0x0800 -> 0100 then 0800.
  - dwell 0 behaves as dwell 1.
  - mode 11 behaves as single.
- Abort and reset: cfg_en_i low at step 2 -> IDLE next cycle, sine_en_o 0, no done_o; re-enable restarts at start. rst_n pulse mid-sweep -> all outputs 0 asynchronously.
